// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch condition codes, resolver states and BTB update record
package cpu_pkg;
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;
    typedef enum logic {IDLE, FLUSH} rs_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } br_update_t;
endpackage

// File: rtl/br_cond.sv
// br_cond: combinational conditional-branch comparator
module br_cond
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        cond
);
    always_comb
        cond = funct3 == BR_EQ  ? rs1 == rs2 :
               funct3 == BR_NE  ? rs1 != rs2 :
               funct3 == BR_LT  ? $signed(rs1) <  $signed(rs2) :
               funct3 == BR_GE  ? $signed(rs1) >= $signed(rs2) :
               funct3 == BR_LTU ? rs1 <  rs2 :
               funct3 == BR_GEU ? rs1 >= rs2 : 1'b0;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution, BTB update, redirect/flush and statistics
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_br,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic [31:0]      ex_imm,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             update_en,
    output logic [31:0]      pc_upd,
    output logic [31:0]      target_upd,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_o,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);
    rs_state_t   state, state_n;
    logic [3:0]  fcnt, fcnt_n;
    logic        cond, accept, taken, mispred, misalign, do_upd, do_redir;
    logic [31:0] sum, target, pc4, actual_next, pred_next;
    br_update_t  upd;
    br_cond u_cond (.funct3(ex_funct3), .rs1(ex_rs1), .rs2(ex_rs2), .cond(cond));
    assign ex_ready    = state == IDLE;
    assign flush_o     = state == FLUSH;
    assign accept      = ex_valid && ex_ready && (ex_is_br || ex_is_jal || ex_is_jalr);
    assign sum         = (ex_is_jalr ? ex_rs1 : ex_pc) + ex_imm;
    assign target      = {sum[31:1], sum[0] & ~ex_is_jalr};
    assign pc4         = ex_pc + 32'd4;
    assign taken       = ex_is_jal || ex_is_jalr || (ex_is_br && cond);
    assign actual_next = taken ? target : pc4;
    assign pred_next   = ex_pred_taken ? ex_pred_target : pc4;
    assign mispred     = actual_next != pred_next;
    assign misalign    = taken && target[1];
    assign do_upd      = accept && taken && !misalign;
    assign do_redir    = accept && mispred && !misalign;
    assign upd         = '{pc: ex_pc, target: target};
    always_comb begin
        state_n = state == FLUSH ? (fcnt == 4'd1 ? IDLE : FLUSH) : (do_redir ? FLUSH : IDLE);
        fcnt_n  = state == FLUSH ? fcnt - 4'd1 : (do_redir ? FC : fcnt);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    // write-side registers: the update/redirect payloads only move when their strobe fires
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            update_en      <= 1'b0;
            redirect_valid <= 1'b0;
            misalign_exc   <= 1'b0;
            pc_upd         <= '0;
            target_upd     <= '0;
            redirect_pc    <= '0;
            br_cnt         <= '0;
            mispred_cnt    <= '0;
        end else begin
            update_en      <= do_upd;
            redirect_valid <= do_redir;
            misalign_exc   <= accept && misalign;
            if (do_upd) begin
                pc_upd     <= upd.pc;
                target_upd <= upd.target;
            end
            if (do_redir) redirect_pc <= actual_next;
            if (accept && !(&br_cnt)) br_cnt <= br_cnt + CNT_W'(1);
            if (do_redir && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench for branch_resolve (default and 4-bit counter instances)
module tb_branch_resolve;
    import cpu_pkg::*;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 0, ex_is_br = 0, ex_is_jal = 0, ex_is_jalr = 0, ex_pred_taken = 0;
    logic [2:0]  ex_funct3 = 0;
    logic [31:0] ex_pc = 0, ex_rs1 = 0, ex_rs2 = 0, ex_imm = 0, ex_pred_target = 0;
    logic        ex_ready, update_en, redirect_valid, flush_o, misalign_exc;
    logic [31:0] pc_upd, target_upd, redirect_pc;
    logic [15:0] br_cnt, mispred_cnt;
    logic        s_ready, s_upd, s_rv, s_flush, s_mis;
    logic [31:0] s_pcu, s_tgu, s_rpc;
    logic [3:0]  s_br, s_mp;
    typedef struct {
        logic        upd;
        logic [31:0] pcu;
        logic [31:0] tgu;
        logic        rv;
        logic [31:0] rpc;
        logic        mis;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    int m_fl = 0, m_br = 0, m_mp = 0, q_br = 0, q_mp = 0;
    always #5 clk = ~clk;
    branch_resolve u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_br(ex_is_br),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .update_en(update_en), .pc_upd(pc_upd),
        .target_upd(target_upd), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_o(flush_o), .misalign_exc(misalign_exc), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );
    branch_resolve #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(s_ready), .ex_is_br(ex_is_br),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .update_en(s_upd), .pc_upd(s_pcu),
        .target_upd(s_tgu), .redirect_valid(s_rv), .redirect_pc(s_rpc),
        .flush_o(s_flush), .misalign_exc(s_mis), .br_cnt(s_br), .mispred_cnt(s_mp)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // kind: 0 bubble, 1 branch, 2 JAL, 3 JALR, 4 valid non-control
    task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] pc, rs1, rs2, imm,
                         input logic pt, input logic [31:0] ptg);
        exp_t e;
        logic cond, taken, acc, mp, ms;
        logic [31:0] tgt, an, pn;
        @(negedge clk);
        ex_valid = kind != 0; ex_is_br = kind == 1; ex_is_jal = kind == 2; ex_is_jalr = kind == 3;
        ex_funct3 = f3; ex_pc = pc; ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptg;
        case (f3)
            3'b000: cond = rs1 == rs2;
            3'b001: cond = rs1 != rs2;
            3'b100: cond = $signed(rs1) < $signed(rs2);
            3'b101: cond = $signed(rs1) >= $signed(rs2);
            3'b110: cond = rs1 < rs2;
            3'b111: cond = rs1 >= rs2;
            default: cond = 1'b0;
        endcase
        tgt   = kind == 3 ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
        taken = kind == 2 || kind == 3 || (kind == 1 && cond);
        an    = taken ? tgt : pc + 32'd4;
        pn    = pt ? ptg : pc + 32'd4;
        acc   = m_fl == 0 && kind >= 1 && kind <= 3;
        mp    = an != pn;
        ms    = taken && tgt[1];
        e.upd = acc && taken && !ms; e.pcu = pc; e.tgu = tgt;
        e.rv  = acc && mp && !ms; e.rpc = an; e.mis = acc && ms;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (m_fl > 0) m_fl--;
        else if (e.rv) m_fl = 2;
        if (acc) begin
            m_br = m_br < 65535 ? m_br + 1 : m_br;
            q_br = q_br < 15 ? q_br + 1 : q_br;
        end
        if (e.rv) begin
            m_mp = m_mp < 65535 ? m_mp + 1 : m_mp;
            q_mp = q_mp < 15 ? q_mp + 1 : q_mp;
        end
        e = sb.pop_front();
        chk("update_en", 32'(update_en), 32'(e.upd));
        if (e.upd) begin
            chk("pc_upd", pc_upd, e.pcu);
            chk("target_upd", target_upd, e.tgu);
        end
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
        chk("misalign_exc", 32'(misalign_exc), 32'(e.mis));
        chk("flush_o", 32'(flush_o), 32'(m_fl > 0));
        chk("ex_ready", 32'(ex_ready), 32'(m_fl == 0));
        chk("br_cnt", 32'(br_cnt), 32'(m_br));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mp));
        chk("sat_br_cnt", 32'(s_br), 32'(q_br));
        chk("sat_mispred_cnt", 32'(s_mp), 32'(q_mp));
        chk("sat_update_en", 32'(s_upd), 32'(e.upd));
    endtask
    task automatic check_reset_state();
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_flush_o", 32'(flush_o), 32'd0);
        chk("rst_update_en", 32'(update_en), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_misalign", 32'(misalign_exc), 32'd0);
        chk("rst_pc_upd", pc_upd, 32'd0);
        chk("rst_target_upd", target_upd, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_br_cnt", 32'(br_cnt), 32'd0);
        chk("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
        chk("rst_sat_flush", 32'(s_flush), 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        issue(1, BR_EQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
        issue(1, BR_NE, 32'h300, 32'd1, 32'd2, 32'h40, 1'b0, 32'h0);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(1, BR_LT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h210);
        issue(1, BR_LTU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h210);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(3, 3'b000, 32'h400, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1002);
        issue(3, 3'b000, 32'h404, 32'h1006, 32'h0, 32'h0, 1'b1, 32'h1006);
        issue(3, 3'b000, 32'h408, 32'h1001, 32'h0, 32'h3, 1'b1, 32'h1004);
        issue(2, 3'b000, 32'h500, 32'h0, 32'h0, 32'h80, 1'b1, 32'h580);
        issue(4, 3'b000, 32'h504, 32'h1, 32'h1, 32'h8, 1'b0, 32'h0);
        issue(1, 3'b010, 32'h600, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0);
        issue(1, BR_GE, 32'h700, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 1'b1, 32'h6F0);
        issue(1, BR_GEU, 32'h710, 32'd3, 32'hFFFF_FFFE, 32'h20, 1'b1, 32'h730);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(2, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(2, 3'b000, 32'h800, 32'h0, 32'h0, 32'h40, 1'b0, 32'h0);
        issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state();
        m_fl = 0; m_br = 0; m_mp = 0; q_br = 0; q_mp = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            issue(2, 3'b000, 32'(i * 16), 32'h0, 32'h0, 32'h40, 1'b0, 32'h0);
            issue(1, BR_EQ, 32'h900, 32'd0, 32'd0, 32'h10, 1'b0, 32'h0);
            issue(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        end
        chk("sat_br_final", 32'(s_br), 32'hF);
        chk("sat_mispred_final", 32'(s_mp), 32'hF);
        chk("wide_br_final", 32'(br_cnt), 32'd20);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
